// File: rtl/m1_stage.sv
// M1 memory sub-stage: latches the EX->M1 bus, issues one DCache request per memory
// instruction and forwards to MEM. Define M1_ADDR_CHECK_EN to enable alignment-error detection.
module m1_stage #(
  parameter int M1_BUS_WD = 116
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_m1s_valid,
  input  logic [M1_BUS_WD-1:0] es_to_m1s_bus,
  output logic                 m1s_allowin,
  input  logic                 ms_allowin,
  output logic                 m1s_to_ms_valid,
  output logic [M1_BUS_WD-1:0] m1s_to_ms_bus,
  input  logic                 flush,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [3:0]           data_wstrb,
  output logic [31:0]          data_addr,
  output logic [31:0]          data_wdata,
  input  logic                 data_addr_ok,
  output logic [4:0]           M1_dest,
  output logic                 M1_load
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t               state_reg;
  logic                 m1s_valid_reg;
  logic [M1_BUS_WD-1:0] bus_reg;

  logic        cur_ex;
  logic [31:0] cur_rt;
  logic [11:0] cur_mem;
  logic        cur_rfm;
  logic [4:0]  cur_dest;
  logic [31:0] cur_alu;
  logic [1:0]  cur_a;
  logic [11:0] in_mem;
  logic [1:0]  in_a;
  logic        cur_addr_err;
  logic        in_addr_err;
  logic        cur_ex_eff;
  logic        in_ex_eff;
  logic        m1s_ready_go;
  logic        accept;
  logic        leave;

  assign cur_ex   = bus_reg[115];
  assign cur_rt   = bus_reg[114:83];
  assign cur_mem  = bus_reg[82:71];
  assign cur_rfm  = bus_reg[70];
  assign cur_dest = bus_reg[68:64];
  assign cur_alu  = bus_reg[63:32];
  assign cur_a    = cur_alu[1:0];
  assign in_mem   = es_to_m1s_bus[82:71];
  assign in_a     = es_to_m1s_bus[33:32];

`ifdef M1_ADDR_CHECK_EN
  // Word ops need a==0, halfword ops need a[0]==0; byte and unaligned ops never fault.
  assign cur_addr_err = ((cur_mem[0] | cur_mem[1]) & (cur_a != 2'b00))
                      | ((cur_mem[4] | cur_mem[5] | cur_mem[9]) & cur_a[0]);
  assign in_addr_err  = ((in_mem[0] | in_mem[1]) & (in_a != 2'b00))
                      | ((in_mem[4] | in_mem[5] | in_mem[9]) & in_a[0]);
`else
  assign cur_addr_err = 1'b0;
  assign in_addr_err  = 1'b0;
`endif

  assign cur_ex_eff = cur_ex | cur_addr_err;
  assign in_ex_eff  = es_to_m1s_bus[115] | in_addr_err;

  assign m1s_ready_go = (cur_mem == 12'd0) | cur_ex_eff | (state_reg == DONE);
  // While a request is outstanding (even a flushed one) nothing may enter.
  assign m1s_allowin  = (state_reg != REQ) & (~m1s_valid_reg | (m1s_ready_go & ms_allowin));
  assign accept       = m1s_allowin & es_to_m1s_valid & ~flush;
  assign leave        = m1s_valid_reg & m1s_ready_go & ms_allowin;

  assign m1s_to_ms_valid = m1s_valid_reg & m1s_ready_go & ~flush;
  assign m1s_to_ms_bus   = {cur_ex_eff, bus_reg[M1_BUS_WD-2:0]};

  assign data_req  = (state_reg == REQ);
  assign data_addr = {cur_alu[31:2], 2'b00};
  assign data_wr   = cur_mem[1] | cur_mem[8] | cur_mem[9] | cur_mem[10] | cur_mem[11];

  assign M1_dest = cur_dest & {5{m1s_valid_reg}};
  assign M1_load = m1s_valid_reg & cur_rfm;

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = cur_rt;
    if (cur_mem[8]) begin
      data_wstrb = 4'b0001 << cur_a;
      data_wdata = {4{cur_rt[7:0]}};
    end else if (cur_mem[9]) begin
      data_wstrb = cur_a[1] ? 4'b1100 : 4'b0011;
      data_wdata = {2{cur_rt[15:0]}};
    end else if (cur_mem[1]) begin
      data_wstrb = 4'b1111;
    end else if (cur_mem[10]) begin
      data_wstrb = 4'b1111 >> (~cur_a);
      data_wdata = cur_rt >> {~cur_a, 3'b000};
    end else if (cur_mem[11]) begin
      data_wstrb = 4'b1111 << cur_a;
      data_wdata = cur_rt << {cur_a, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      m1s_valid_reg <= 1'b0;
      bus_reg       <= '0;
    end else begin
      if (flush) begin
        m1s_valid_reg <= 1'b0;
      end else if (m1s_allowin) begin
        m1s_valid_reg <= es_to_m1s_valid;
      end
      if (accept) begin
        bus_reg <= es_to_m1s_bus;
      end
      case (state_reg)
        REQ: begin
          // A flushed request still completes its handshake, then returns to IDLE.
          if (data_addr_ok) begin
            state_reg <= (m1s_valid_reg && !flush) ? DONE : IDLE;
          end
        end
        default: begin
          if (flush) begin
            state_reg <= IDLE;
          end else if (accept) begin
            state_reg <= ((in_mem != 12'd0) && !in_ex_eff) ? REQ : IDLE;
          end else if (leave) begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m1_stage.sv
// Self-checking bench for m1_stage: vector table plus hand-written flush, stall and back-to-back sequences.
module tb_m1_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_valid;
  logic [115:0] es_bus;
  logic         m1s_allowin;
  logic         ms_allowin;
  logic         m1s_to_ms_valid;
  logic [115:0] m1s_to_ms_bus;
  logic         flush;
  logic         data_req;
  logic         data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr;
  logic [31:0]  data_wdata;
  logic         data_addr_ok;
  logic [4:0]   M1_dest;
  logic         M1_load;

  m1_stage dut (
    .clk(clk), .reset(reset),
    .es_to_m1s_valid(es_valid), .es_to_m1s_bus(es_bus),
    .m1s_allowin(m1s_allowin), .ms_allowin(ms_allowin),
    .m1s_to_ms_valid(m1s_to_ms_valid), .m1s_to_ms_bus(m1s_to_ms_bus),
    .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .M1_dest(M1_dest), .M1_load(M1_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mem;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        ex_in;
    int          delay;
    logic        exp_req;
    logic        exp_wr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_ex;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  int checks = 0;
  int errors = 0;
  logic [115:0] out_q[$];
  req_t         req_q[$];
  vec_t         vecs[12];

  localparam logic [11:0] LW = 12'h001, SW = 12'h002, LBU = 12'h008, LH = 12'h010;
  localparam logic [11:0] SB = 12'h100, SH = 12'h200, SWL = 12'h400, SWR = 12'h800;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [115:0] mk_bus(input logic [11:0] mem, input logic [31:0] addr,
                                          input logic [31:0] rt, input logic ex,
                                          input logic [4:0] dest, input logic [31:0] pc);
    logic rfm;
    logic gr_we;
    rfm   = |{mem[7:2], mem[0]};
    gr_we = rfm | (mem == 12'd0);
    return {ex, rt, mem, rfm, gr_we, dest, addr, pc};
  endfunction

  function automatic vec_t mkv(input logic [11:0] mem, input logic [31:0] addr, input logic [31:0] rt,
                               input logic ex_in, input int delay, input logic exp_req,
                               input logic [3:0] strb, input logic [31:0] wdata, input logic exp_ex);
    vec_t v;
    v.mem = mem; v.addr = addr; v.rt = rt; v.ex_in = ex_in; v.delay = delay;
    v.exp_req = exp_req; v.exp_wr = |{mem[11:8], mem[1]}; v.exp_strb = strb;
    v.exp_wdata = wdata; v.exp_ex = exp_ex;
    return v;
  endfunction

  task automatic push_exp(input logic [115:0] b, input logic ex, input logic req,
                          input logic wr, input logic [3:0] strb, input logic [31:0] wdata);
    logic [115:0] e;
    req_t r;
    e = b;
    e[115] = ex;
    out_q.push_back(e);
    if (req) begin
      r.addr = {b[63:34], 2'b00}; r.wr = wr; r.strb = strb; r.wdata = wdata;
      req_q.push_back(r);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [115:0] b;
    b = mk_bus(v.mem, v.addr, v.rt, v.ex_in, idx[4:0], 32'hBFC0_0000 + idx * 4);
    @(posedge clk); #1;
    chk("allowin_before_issue", m1s_allowin, 1'b1);
    es_valid = 1'b1;
    es_bus   = b;
    push_exp(b, v.exp_ex, v.exp_req, v.exp_wr, v.exp_strb, v.exp_wdata);
    @(posedge clk); #1;
    es_valid = 1'b0;
    if (v.exp_req) begin
      for (int i = 1; i <= v.delay; i++) begin
        if (i == v.delay) data_addr_ok = 1'b1;
        @(negedge clk);
        chk("req_asserted", data_req, 1'b1);
        chk("no_early_out", m1s_to_ms_valid, 1'b0);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
      end
    end
    @(negedge clk);
    chk("out_valid", m1s_to_ms_valid, 1'b1);
    chk("req_low_after", data_req, 1'b0);
    $display("vec %0d mem=%03h addr=%08h rt=%08h req=%0b ex=%0b", idx, v.mem, v.addr, v.rt,
             v.exp_req, v.exp_ex);
  endtask

  // Scoreboard monitor: checks request stability, pops requests and M1->MS transfers.
  logic        prev_req, prev_ok, prev_wr;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_strb;
  req_t        mon_r;
  logic [115:0] mon_b;

  always @(negedge clk) begin
    if (reset) begin
      prev_req <= 1'b0;
      prev_ok  <= 1'b0;
    end else begin
      if (prev_req && !prev_ok)
        chk("req_stable", {data_req, data_addr, data_wr, data_wstrb, data_wdata},
            {1'b1, prev_addr, prev_wr, prev_strb, prev_wdata});
      if (data_req && data_addr_ok) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 1'b1, 1'b0);
        end else begin
          mon_r = req_q.pop_front();
          chk("req_addr", data_addr, mon_r.addr);
          chk("req_wr", data_wr, mon_r.wr);
          chk("req_wstrb", data_wstrb, mon_r.strb);
          if (mon_r.wr) chk("req_wdata", data_wdata, mon_r.wdata);
          $display("req addr=%08h wr=%0b strb=%04b wdata=%08h", data_addr, data_wr, data_wstrb, data_wdata);
        end
      end
      if (m1s_to_ms_valid && ms_allowin) begin
        if (out_q.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          mon_b = out_q.pop_front();
          chk("out_bus", m1s_to_ms_bus, mon_b);
          $display("out pc=%08h ex=%0b", m1s_to_ms_bus[31:0], m1s_to_ms_bus[115]);
        end
      end
      prev_req   <= data_req;
      prev_ok    <= data_addr_ok;
      prev_addr  <= data_addr;
      prev_wr    <= data_wr;
      prev_strb  <= data_wstrb;
      prev_wdata <= data_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [115:0] b1, b2;

    vecs[0]  = mkv(LW,  32'h8000_0004, 32'h0,          1'b0, 3, 1'b1, 4'b0000, 32'h0,          1'b0);
    vecs[1]  = mkv(SB,  32'h0000_1002, 32'h1234_56AB, 1'b0, 1, 1'b1, 4'b0100, 32'hABAB_ABAB, 1'b0);
    vecs[2]  = mkv(SWL, 32'h0000_2001, 32'hAABB_CCDD, 1'b0, 2, 1'b1, 4'b0011, 32'h0000_AABB, 1'b0);
    vecs[3]  = mkv(SWR, 32'h0000_2003, 32'hAABB_CCDD, 1'b0, 1, 1'b1, 4'b1000, 32'hDD00_0000, 1'b0);
    vecs[4]  = mkv(SH,  32'h0000_3002, 32'h1111_BEEF, 1'b0, 1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0);
    vecs[5]  = mkv(SW,  32'h0000_4000, 32'h0BAD_F00D, 1'b0, 4, 1'b1, 4'b1111, 32'h0BAD_F00D, 1'b0);
    vecs[6]  = mkv(LBU, 32'h0000_5003, 32'h0,          1'b0, 1, 1'b1, 4'b0000, 32'h0,          1'b0);
    vecs[7]  = mkv(12'h0, 32'h1234_5677, 32'h5,        1'b0, 1, 1'b0, 4'b0000, 32'h0,          1'b0);
`ifdef M1_ADDR_CHECK_EN
    vecs[8]  = mkv(LH,  32'h0000_6001, 32'h0,          1'b0, 1, 1'b0, 4'b0000, 32'h0,          1'b1);
    vecs[9]  = mkv(SW,  32'h0000_6002, 32'h7777_8888, 1'b0, 1, 1'b0, 4'b0000, 32'h0,          1'b1);
`else
    vecs[8]  = mkv(LH,  32'h0000_6001, 32'h0,          1'b0, 2, 1'b1, 4'b0000, 32'h0,          1'b0);
    vecs[9]  = mkv(SW,  32'h0000_6002, 32'h7777_8888, 1'b0, 1, 1'b1, 4'b1111, 32'h7777_8888, 1'b0);
`endif
    vecs[10] = mkv(SW,  32'h0000_7000, 32'h1,          1'b1, 1, 1'b0, 4'b0000, 32'h0,          1'b1);
    vecs[11] = mkv(SWL, 32'h0000_8003, 32'h0102_0304, 1'b0, 1, 1'b1, 4'b1111, 32'h0102_0304, 1'b0);

    reset = 1'b1; es_valid = 1'b0; es_bus = '0; ms_allowin = 1'b1; flush = 1'b0; data_addr_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_req", data_req, 1'b0);
    chk("reset_out_valid", m1s_to_ms_valid, 1'b0);
    chk("reset_dest", M1_dest, 5'd0);
    chk("reset_load", M1_load, 1'b0);
    chk("reset_allowin", m1s_allowin, 1'b1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Flush while a request is outstanding: request held, one handshake, nothing to MEM.
    b1 = mk_bus(LW, 32'h3000_0000, 32'h0, 1'b0, 5'd3, 32'hBFC0_1000);
    @(posedge clk); #1;
    es_valid = 1'b1; es_bus = b1;
    push_exp(b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0);
    void'(out_q.pop_back());
    @(posedge clk); #1;
    es_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_no_out", m1s_to_ms_valid, 1'b0);
    chk("flush_req_held", data_req, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_req_held2", data_req, 1'b1);
    chk("flush_allowin_low", m1s_allowin, 1'b0);
    chk("flush_load_cleared", M1_load, 1'b0);
    @(posedge clk); #1;
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("flush_req_at_ok", data_req, 1'b1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("flush_req_dropped", data_req, 1'b0);
    chk("flush_allowin_back", m1s_allowin, 1'b1);
    chk("flush_out_never", m1s_to_ms_valid, 1'b0);
    $display("seq flush_in_req done");

    // MEM stalls for 5 cycles after the handshake: no second request.
    ms_allowin = 1'b0;
    b1 = mk_bus(LW, 32'h2000_0010, 32'h0, 1'b0, 5'd9, 32'hBFC0_2000);
    @(posedge clk); #1;
    es_valid = 1'b1; es_bus = b1;
    push_exp(b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0);
    @(posedge clk); #1;
    es_valid = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    chk("stall_req", data_req, 1'b1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_req", data_req, 1'b0);
      chk("stall_out_valid", m1s_to_ms_valid, 1'b1);
      chk("stall_allowin", m1s_allowin, 1'b0);
      chk("stall_dest", M1_dest, 5'd9);
      chk("stall_load", M1_load, 1'b1);
      @(posedge clk); #1;
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    chk("stall_release", m1s_to_ms_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_gone", m1s_to_ms_valid, 1'b0);
    $display("seq ms_stall done");

    // Back-to-back: new store enters as the finished load leaves, straight into REQ.
    b1 = mk_bus(LW, 32'h4000_0020, 32'h0, 1'b0, 5'd4, 32'hBFC0_3000);
    b2 = mk_bus(SW, 32'h1000_0008, 32'hCAFE_F00D, 1'b0, 5'd0, 32'hBFC0_3004);
    @(posedge clk); #1;
    es_valid = 1'b1; es_bus = b1;
    push_exp(b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0);
    @(posedge clk); #1;
    es_valid = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    chk("b2b_req1", data_req, 1'b1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    es_valid = 1'b1; es_bus = b2;
    push_exp(b2, 1'b0, 1'b1, 1'b1, 4'b1111, 32'hCAFE_F00D);
    @(negedge clk);
    chk("b2b_allowin", m1s_allowin, 1'b1);
    chk("b2b_out1", m1s_to_ms_valid, 1'b1);
    @(posedge clk); #1;
    es_valid = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    chk("b2b_req2", data_req, 1'b1);
    chk("b2b_wr2", data_wr, 1'b1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("b2b_out2", m1s_to_ms_valid, 1'b1);
    chk("b2b_req_low", data_req, 1'b0);
    $display("seq back_to_back done");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("out_queue_empty", out_q.size(), 0);
    chk("req_queue_empty", req_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
